// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and FSM encoding for the register-file write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_write_arbiter_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    // Register index that acts as the program counter; never lands in the register file.
    localparam logic [ADDR_W-1:0] PC_REG = 4'd15;
    // Link register targeted by BL.
    localparam logic [ADDR_W-1:0] LR_REG = 4'd14;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback-beat, register-file write port and bypass lookup bundle.
// Latency: n/a (wiring only).
// Backpressure: wb_valid/wb_ready handshake on the writeback side.
interface regfile_write_arbiter_if #(
    parameter int ADDR_W = regfile_write_arbiter_pkg::ADDR_W,
    parameter int DATA_W = regfile_write_arbiter_pkg::DATA_W
);

    // writeback side
    logic              wb_valid;
    logic              wb_ready;
    logic              wb_wr0;
    logic [ADDR_W-1:0] wb_addr0;
    logic [DATA_W-1:0] wb_data0;
    logic              wb_wr1;
    logic [ADDR_W-1:0] wb_addr1;
    logic [DATA_W-1:0] wb_data1;

    // register-file write port and PC redirect
    logic              regwr;
    logic [ADDR_W-1:0] regaddrIn;
    logic [DATA_W-1:0] regdataIn;
    logic              pc_wr;
    logic [DATA_W-1:0] pc_data;

    // bypass lookup
    logic [ADDR_W-1:0] rdaddr_a;
    logic [ADDR_W-1:0] rdaddr_b;
    logic              byp_hit_a;
    logic [DATA_W-1:0] byp_data_a;
    logic              byp_hit_b;
    logic [DATA_W-1:0] byp_data_b;

    modport slave (
        input  wb_valid, wb_wr0, wb_addr0, wb_data0, wb_wr1, wb_addr1, wb_data1,
        input  rdaddr_a, rdaddr_b,
        output wb_ready, regwr, regaddrIn, regdataIn, pc_wr, pc_data,
        output byp_hit_a, byp_data_a, byp_hit_b, byp_data_b
    );

    modport master (
        output wb_valid, wb_wr0, wb_addr0, wb_data0, wb_wr1, wb_addr1, wb_data1,
        output rdaddr_a, rdaddr_b,
        input  wb_ready, regwr, regaddrIn, regdataIn, pc_wr, pc_data,
        input  byp_hit_a, byp_data_a, byp_hit_b, byp_data_b
    );

endinterface

// File: rtl/regfile_write_arbiter_byp_lookup.sv
// Priority match of one read address against the in-flight write entries.
// Latency: combinational.
// Backpressure: none.
module byp_lookup
    import regfile_write_arbiter_pkg::*;
#(
    parameter int              AW     = regfile_write_arbiter_pkg::ADDR_W,
    parameter int              DW     = regfile_write_arbiter_pkg::DATA_W,
    parameter logic [AW-1:0]   PC_IDX = regfile_write_arbiter_pkg::PC_REG
) (
    input  logic [AW-1:0] rdaddr,
    // held write, newest source
    input  logic          hold_vld,
    input  logic [AW-1:0] hold_addr,
    input  logic [DW-1:0] hold_dat,
    // write currently on the register-file port, older source
    input  logic          out_vld,
    input  logic [AW-1:0] out_addr,
    input  logic [DW-1:0] out_dat,
    output logic          hit,
    output logic [DW-1:0] dat
);

    // Newest source wins; PC reads are served by the fetch path, so they never hit.
    always_comb begin
        hit = 1'b0;
        dat = '0;
        if (rdaddr != PC_IDX) begin
            if (hold_vld && (hold_addr == rdaddr)) begin
                hit = 1'b1;
                dat = hold_dat;
            end else if (out_vld && (out_addr == rdaddr)) begin
                hit = 1'b1;
                dat = out_dat;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Serialises up to two writeback writes per beat onto one register-file write port, redirecting PC writes.
// Latency: first write of a beat registered one cycle after acceptance; the second write one cycle later.
// Backpressure: wb_ready drops for one cycle while a held second write drains.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int                  ADDR_W = regfile_write_arbiter_pkg::ADDR_W,
    parameter int                  DATA_W = regfile_write_arbiter_pkg::DATA_W,
    parameter logic [ADDR_W-1:0]   PC_REG = regfile_write_arbiter_pkg::PC_REG
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } wr_ent_t;

    arb_state_t state, state_nxt;

    wr_ent_t hold, hold_nxt;
    wr_ent_t emit;

    logic              regwr_q;
    logic [ADDR_W-1:0] regaddr_q;
    logic [DATA_W-1:0] regdata_q;
    logic              pc_wr_q;
    logic [DATA_W-1:0] pc_data_q;

    logic emit_is_pc;

    // Beats are only taken in IDLE; DRAIN is the single stall cycle for the held write.
    assign bus.wb_ready = (state == IDLE);

    // Next-state, hold-buffer update and selection of the write to emit this cycle.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        emit      = '0;
        case (state)
            IDLE: begin
                if (bus.wb_valid) begin
                    if (bus.wb_wr0) begin
                        emit = '{vld: 1'b1, addr: bus.wb_addr0, dat: bus.wb_data0};
                        // Same destination on both channels: load data wins, base writeback is dropped.
                        if (bus.wb_wr1 && (bus.wb_addr0 != bus.wb_addr1)) begin
                            hold_nxt  = '{vld: 1'b1, addr: bus.wb_addr1, dat: bus.wb_data1};
                            state_nxt = DRAIN;
                        end
                    end else if (bus.wb_wr1) begin
                        emit = '{vld: 1'b1, addr: bus.wb_addr1, dat: bus.wb_data1};
                    end
                end
            end
            DRAIN: begin
                emit         = hold;
                hold_nxt.vld = 1'b0;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state and hold buffer; reset discards any held write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
        end
    end

    assign emit_is_pc = (emit.addr == PC_REG);

    // Registered write port and PC strobe; address/data registers keep their last value between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            regwr_q   <= 1'b0;
            regaddr_q <= '0;
            regdata_q <= '0;
            pc_wr_q   <= 1'b0;
            pc_data_q <= '0;
        end else begin
            regwr_q <= emit.vld && !emit_is_pc;
            pc_wr_q <= emit.vld && emit_is_pc;
            if (emit.vld && !emit_is_pc) begin
                regaddr_q <= emit.addr;
                regdata_q <= emit.dat;
            end
            if (emit.vld && emit_is_pc) begin
                pc_data_q <= emit.dat;
            end
        end
    end

    assign bus.regwr     = regwr_q;
    assign bus.regaddrIn = regaddr_q;
    assign bus.regdataIn = regdata_q;
    assign bus.pc_wr     = pc_wr_q;
    assign bus.pc_data   = pc_data_q;

    logic hold_live;
    assign hold_live = (state == DRAIN) && hold.vld;

    byp_lookup #(
        .AW     (ADDR_W),
        .DW     (DATA_W),
        .PC_IDX (PC_REG)
    ) u_byp_a (
        .rdaddr    (bus.rdaddr_a),
        .hold_vld  (hold_live),
        .hold_addr (hold.addr),
        .hold_dat  (hold.dat),
        .out_vld   (regwr_q),
        .out_addr  (regaddr_q),
        .out_dat   (regdata_q),
        .hit       (bus.byp_hit_a),
        .dat       (bus.byp_data_a)
    );

    byp_lookup #(
        .AW     (ADDR_W),
        .DW     (DATA_W),
        .PC_IDX (PC_REG)
    ) u_byp_b (
        .rdaddr    (bus.rdaddr_b),
        .hold_vld  (hold_live),
        .hold_addr (hold.addr),
        .hold_dat  (hold.dat),
        .out_vld   (regwr_q),
        .out_addr  (regaddr_q),
        .out_dat   (regdata_q),
        .hit       (bus.byp_hit_b),
        .dat       (bus.byp_data_b)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for the register-file write arbiter.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises the one-cycle wb_ready stall on dual writes.
module tb_regfile_write_arbiter;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    regfile_write_arbiter_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    regfile_write_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v,
                        input logic w0, input logic [3:0] a0, input logic [31:0] d0,
                        input logic w1, input logic [3:0] a1, input logic [31:0] d1);
        bus.wb_valid = v;
        bus.wb_wr0   = w0;
        bus.wb_addr0 = a0;
        bus.wb_data0 = d0;
        bus.wb_wr1   = w1;
        bus.wb_addr1 = a1;
        bus.wb_data1 = d1;
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle();
        bus.rdaddr_a = 4'd0;
        bus.rdaddr_b = 4'd0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        check("rst_regwr",   32'(bus.regwr),     32'd0);
        check("rst_addr",    32'(bus.regaddrIn), 32'd0);
        check("rst_data",    bus.regdataIn,      32'd0);
        check("rst_pc_wr",   32'(bus.pc_wr),     32'd0);
        check("rst_pc_data", bus.pc_data,        32'd0);
        check("rst_ready",   32'(bus.wb_ready),  32'd1);

        // single write
        beat(1'b1, 1'b1, 4'd3, 32'h1234, 1'b0, 4'd0, 32'h0);
        tick();
        check("single_regwr", 32'(bus.regwr),     32'd1);
        check("single_addr",  32'(bus.regaddrIn), 32'd3);
        check("single_data",  bus.regdataIn,      32'h1234);
        check("single_ready", 32'(bus.wb_ready),  32'd1);
        idle();
        tick();
        check("pulse_regwr", 32'(bus.regwr),     32'd0);
        check("hold_addr",   32'(bus.regaddrIn), 32'd3);
        check("hold_data",   bus.regdataIn,      32'h1234);

        // dual write with a follow-on beat held during the stall
        beat(1'b1, 1'b1, 4'd2, 32'hAAAA5555, 1'b1, 4'd5, 32'h00000104);
        bus.rdaddr_a = 4'd5;
        bus.rdaddr_b = 4'd2;
        tick();
        check("dual1_regwr", 32'(bus.regwr),     32'd1);
        check("dual1_addr",  32'(bus.regaddrIn), 32'd2);
        check("dual1_data",  bus.regdataIn,      32'hAAAA5555);
        check("dual1_ready", 32'(bus.wb_ready),  32'd0);
        check("byp_a_hit",   32'(bus.byp_hit_a), 32'd1);
        check("byp_a_data",  bus.byp_data_a,     32'h00000104);
        check("byp_b_hit",   32'(bus.byp_hit_b), 32'd1);
        check("byp_b_data",  bus.byp_data_b,     32'hAAAA5555);
        bus.rdaddr_a = 4'd15;
        #1;
        check("byp_pc_miss", 32'(bus.byp_hit_a), 32'd0);
        beat(1'b1, 1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'h0);
        tick();
        check("dual2_regwr", 32'(bus.regwr),     32'd1);
        check("dual2_addr",  32'(bus.regaddrIn), 32'd5);
        check("dual2_data",  bus.regdataIn,      32'h00000104);
        check("dual2_ready", 32'(bus.wb_ready),  32'd1);
        tick();
        idle();
        check("held_regwr", 32'(bus.regwr),     32'd1);
        check("held_addr",  32'(bus.regaddrIn), 32'd7);
        check("held_data",  bus.regdataIn,      32'h77);
        bus.rdaddr_a = 4'd7;
        bus.rdaddr_b = 4'd5;
        #1;
        check("byp_out_hit",  32'(bus.byp_hit_a), 32'd1);
        check("byp_out_data", bus.byp_data_a,      32'h77);
        check("byp_old_miss", 32'(bus.byp_hit_b), 32'd0);

        // same-address collision: channel 0 wins, no stall
        beat(1'b1, 1'b1, 4'd4, 32'h11, 1'b1, 4'd4, 32'h22);
        tick();
        idle();
        check("coll_regwr", 32'(bus.regwr),     32'd1);
        check("coll_addr",  32'(bus.regaddrIn), 32'd4);
        check("coll_data",  bus.regdataIn,      32'h11);
        check("coll_ready", 32'(bus.wb_ready),  32'd1);
        tick();
        check("coll_no_second", 32'(bus.regwr), 32'd0);

        // PC redirect on channel 0
        beat(1'b1, 1'b1, 4'd15, 32'h200, 1'b0, 4'd0, 32'h0);
        tick();
        idle();
        check("pc_pc_wr",   32'(bus.pc_wr),     32'd1);
        check("pc_pc_data", bus.pc_data,        32'h200);
        check("pc_regwr",   32'(bus.regwr),     32'd0);
        check("pc_addr",    32'(bus.regaddrIn), 32'd4);
        tick();
        check("pc_pulse", 32'(bus.pc_wr), 32'd0);

        // BL: link write then PC redirect from channel 1
        beat(1'b1, 1'b1, 4'd14, 32'h104, 1'b1, 4'd15, 32'h300);
        tick();
        idle();
        check("bl1_regwr", 32'(bus.regwr),     32'd1);
        check("bl1_addr",  32'(bus.regaddrIn), 32'd14);
        check("bl1_pc_wr", 32'(bus.pc_wr),     32'd0);
        check("bl1_ready", 32'(bus.wb_ready),  32'd0);
        tick();
        check("bl2_pc_wr",   32'(bus.pc_wr),     32'd1);
        check("bl2_pc_data", bus.pc_data,        32'h300);
        check("bl2_regwr",   32'(bus.regwr),     32'd0);
        check("bl2_addr",    32'(bus.regaddrIn), 32'd14);
        check("bl2_ready",   32'(bus.wb_ready),  32'd1);

        // channel-1-only beat and empty beat
        beat(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 32'h99);
        tick();
        check("ch1_addr", 32'(bus.regaddrIn), 32'd9);
        check("ch1_data", bus.regdataIn,      32'h99);
        beat(1'b1, 1'b0, 4'd1, 32'h5, 1'b0, 4'd6, 32'h6);
        tick();
        idle();
        check("empty_regwr", 32'(bus.regwr),    32'd0);
        check("empty_pc_wr", 32'(bus.pc_wr),    32'd0);
        check("empty_ready", 32'(bus.wb_ready), 32'd1);

        // reset while draining discards the held write
        beat(1'b1, 1'b1, 4'd2, 32'hDEAD0002, 1'b1, 4'd5, 32'hDEAD0005);
        tick();
        idle();
        check("rd1_regwr", 32'(bus.regwr),    32'd1);
        check("rd1_ready", 32'(bus.wb_ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.rdaddr_a = 4'd5;
        #1;
        check("rd2_regwr",   32'(bus.regwr),     32'd0);
        check("rd2_pc_wr",   32'(bus.pc_wr),     32'd0);
        check("rd2_ready",   32'(bus.wb_ready),  32'd1);
        check("rd2_addr",    32'(bus.regaddrIn), 32'd0);
        check("rd2_byp_miss", 32'(bus.byp_hit_a), 32'd0);
        tick();
        check("rd3_regwr", 32'(bus.regwr), 32'd0);
        check("rd3_pc_wr", 32'(bus.pc_wr), 32'd0);
        tick();
        check("rd4_regwr", 32'(bus.regwr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
